// File: rtl/goldschmidt_div_ctrl.sv
// Goldschmidt significand divider controller: owns the N/D iteration registers,
// time-shares one 19x19 multiplier between the N and D updates, rounds RNE.
module goldschmidt_div_ctrl #(
  parameter int ITER = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] n,
  input  logic [15:0] d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        out_err
);

  typedef enum logic [2:0] {IDLE, MULN, MULD, FIN, DONE} state_t;

  localparam logic [3:0] ITER_L = 4'(ITER);

  state_t      state_q, state_d;
  logic [18:0] n_q, n_d, d_q, d_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_inc;
  logic        err_q, err_d;
  logic [15:0] q_q, q_d;
  logic        oerr_q, oerr_d;

  logic [18:0] k;
  logic [18:0] mul_a;
  logic [37:0] prod;

  // Q2.36 product -> Q1.18, RNE; overflow or rounding carry saturates.
  function automatic logic [18:0] rne19(input logic [37:0] p);
    logic [18:0] t;
    logic        g, s, up;
    logic [19:0] sum;
    t   = p[36:18];
    g   = p[17];
    s   = |p[16:0];
    up  = g & (s | t[0]);
    sum = {1'b0, t} + {19'd0, up};
    if (p[37] || sum[19]) rne19 = 19'h7FFFF;
    else                  rne19 = sum[18:0];
  endfunction

  function automatic logic [15:0] rne16(input logic [18:0] x);
    logic [15:0] t;
    logic        g, s, up;
    logic [16:0] sum;
    t   = x[18:3];
    g   = x[2];
    s   = |x[1:0];
    up  = g & (s | t[0]);
    sum = {1'b0, t} + {16'd0, up};
    if (sum[16]) rne16 = 16'hFFFF;
    else         rne16 = sum[15:0];
  endfunction

  // K = 2 - D; the single multiplier sees N in MULN and D in MULD.
  assign k       = ~d_q + 19'd1;
  assign mul_a   = (state_q == MULD) ? d_q : n_q;
  assign prod    = {19'd0, mul_a} * {19'd0, k};
  assign cnt_inc = {1'b0, cnt_q} + 4'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    q_d     = q_q;
    oerr_d  = oerr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d   = {1'b0, n, 2'b00};
          d_d   = {1'b0, d, 2'b00};
          cnt_d = 3'd0;
          if (!n[15] || !d[15]) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = MULN;
          end
        end
      end
      MULN: begin
        n_d     = rne19(prod);
        state_d = MULD;
      end
      MULD: begin
        d_d     = rne19(prod);
        cnt_d   = cnt_inc[2:0];
        state_d = (cnt_inc < ITER_L) ? MULN : FIN;
      end
      FIN: begin
        q_d     = err_q ? 16'h0000 : rne16(n_q);
        oerr_d  = err_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 19'd0;
      d_q     <= 19'd0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      q_q     <= 16'd0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      q_q     <= q_d;
      oerr_q  <= oerr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign out_err   = oerr_q;

endmodule

// File: tb/tb_goldschmidt_div_ctrl.sv
// Randomized bench for goldschmidt_div_ctrl against an integer-arithmetic model
// of the Goldschmidt recurrence with per-product round-to-nearest-even.
module tb_goldschmidt_div_ctrl;

  localparam int ITER = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n, d;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  goldschmidt_div_ctrl #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference rounding written as integer division/remainder arithmetic.
  function automatic longint unsigned m_rnd(input longint unsigned p, input int drop,
                                            input longint unsigned maxv);
    longint unsigned unit, t, rem, half;
    unit = 64'd1 << drop;
    half = unit >> 1;
    t    = p / unit;
    rem  = p % unit;
    if (rem > half || (rem == half && (t % 2) == 1)) t = t + 1;
    if (t > maxv) t = maxv;
    return t;
  endfunction

  task automatic golden(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] eq, output logic ee);
    longint unsigned nn, dd, kk, nx, dx;
    if (a < 16'h8000 || b < 16'h8000) begin
      eq = 16'h0000;
      ee = 1'b1;
    end else begin
      nn = longint'(a) * 4;
      dd = longint'(b) * 4;
      for (int i = 0; i < ITER; i++) begin
        kk = (524288 - dd) % 524288;
        nx = m_rnd(nn * kk, 18, 524287);
        dx = m_rnd(dd * kk, 18, 524287);
        nn = nx;
        dd = dx;
      end
      eq = 16'(m_rnd(nn, 3, 65535));
      ee = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit take,
                        output logic [15:0] rq, output logic re);
    logic [15:0] eq;
    logic        ee;
    int          lat, guard;
    bit          seen;
    longint      diff;
    golden(a, b, eq, ee);
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("idle_ready", in_ready, 1);
    n = a;
    d = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ready_drop", in_ready, 0);
    lat = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      tick();
      lat++;
      if (out_valid) seen = 1;
    end
    chk("latency", lat, ee ? 1 : 2 * ITER + 1);
    chk("q", q, eq);
    chk("err", out_err, ee);
    if (!ee) begin
      diff = longint'(q) * longint'(b) - longint'(a) * 32768;
      if (diff < 0) diff = -diff;
      chk("ulp_bound", (diff <= longint'(b)), 1);
    end
    rq = q;
    re = out_err;
    if (take) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ready_after_take", in_ready, 1);
      chk("valid_after_take", out_valid, 0);
    end
  endtask

  initial begin
    logic [15:0] rq, a, b;
    logic        re;
    int          vcount;

    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 16'h8000;
    d = 16'h8000;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_err", out_err, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid || !in_ready) vcount++;
    end
    chk("rst_blocks_accept", vcount, 0);

    run_op(16'h8000, 16'h8000, 1, rq, re);
    chk("one_over_one", rq, 16'h8000);
    run_op(16'hC000, 16'h8000, 1, rq, re);
    chk("1p5_over_1", rq, 16'hC000);
    run_op(16'h8000, 16'hC000, 1, rq, re);
    chk("1_over_1p5", rq, 16'h5555);
    run_op(16'hFFFF, 16'h8000, 1, rq, re);
    chk("near2_no_wrap", rq, 16'hFFFF);

    run_op(16'h8000, 16'h4000, 1, rq, re);
    chk("unnorm_err", re, 1);
    chk("unnorm_q", rq, 0);
    run_op(16'h9000, 16'hB000, 1, rq, re);
    chk("err_cleared", re, 0);

    // Backpressure: result held, new operands ignored.
    run_op(16'h9000, 16'hA000, 0, rq, re);
    for (int i = 0; i < 20; i++) begin
      n = 16'($urandom) | 16'h8000;
      d = 16'($urandom) | 16'h8000;
      in_valid = (i % 3 == 0);
      tick();
      chk("bp_q", q, rq);
      chk("bp_err", out_err, re);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("bp_not_queued", vcount, 0);

    // Reset during MULD of iteration 3.
    n = 16'hD123;
    d = 16'h8765;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_q", q, 0);
    chk("midrst_err", out_err, 0);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("midrst_no_pulse", vcount, 0);
    run_op(16'hD123, 16'h8765, 1, rq, re);

    // Reset while a result is waiting in DONE.
    run_op(16'hA5A5, 16'h8001, 0, rq, re);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_q", q, 0);
    chk("donerst_ready", in_ready, 1);

    for (int i = 0; i < 3000; i++) begin
      a = 16'($urandom) | 16'h8000;
      b = 16'($urandom) | 16'h8000;
      if ($urandom_range(15) == 0) b[15] = 1'b0;
      else if ($urandom_range(15) == 0) a[15] = 1'b0;
      run_op(a, b, 1, rq, re);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
